// File: rtl/bm_rd_ctrl_pkg.sv
// bm_rd_ctrl_pkg: shared bias-memory geometry and read-controller FSM encoding
package bm_rd_ctrl_pkg;
  localparam int BM_DATA_WIDTH = 16;
  localparam int BM_DEPTH      = 64;
  localparam int BM_NUM_PIPE   = 1;
  localparam int BM_AW         = $clog2(BM_DEPTH);
  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_DRAIN, ST_DONE} bm_rd_state_e;
endpackage

// File: rtl/bm_rd_fifo.sv
// bm_rd_fifo: synchronous first-word-fall-through FIFO with occupancy count
module bm_rd_fifo #(
  parameter int WIDTH = 17,
  parameter int DEPTH = 8,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic [CW-1:0]    count,
  output logic             empty
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  assign dout  = mem[rd_ptr];
  assign empty = count == '0;
  // storage and pointers; head is cleared on reset so the output reads zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end
endmodule

// File: rtl/bm_rd_ctrl.sv
// bm_rd_ctrl: bias-memory burst read controller with latency-hiding output FIFO
module bm_rd_ctrl
  import bm_rd_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = BM_DATA_WIDTH,
  parameter int DEPTH      = BM_DEPTH,
  parameter int RD_LAT     = BM_NUM_PIPE + 1,
  parameter int FIFO_DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [AW-1:0]         req_addr,
  input  logic [AW:0]           req_len,
  output logic                  bm_rd_en,
  output logic [AW-1:0]         bm_rd_addr,
  input  logic [DATA_WIDTH-1:0] bm_dout,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic                  done
);
  bm_rd_state_e state_q, state_d;
  logic [AW-1:0] addr_q;
  logic [AW:0] rem_q;
  logic [CW-1:0] inflight, fifo_count;
  logic [RD_LAT-1:0] sr_vld, sr_lst;
  logic fifo_empty, pop, issue_last, credit_ok;
  assign req_ready  = state_q == ST_IDLE;
  assign done       = state_q == ST_DONE;
  assign bm_rd_addr = addr_q;
  assign m_valid    = !fifo_empty;
  assign pop        = m_valid && m_ready;
  assign issue_last = rem_q == (AW+1)'(1);
  assign credit_ok  = (inflight + fifo_count) < CW'(FIFO_DEPTH);
  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else state_q <= state_d;
  end
  // next state and read issue: reads are only issued while a FIFO slot is reserved for them
  always_comb begin
    state_d  = state_q;
    bm_rd_en = 1'b0;
    case (state_q)
      ST_IDLE:  if (req_valid) state_d = (req_len == '0) ? ST_DONE : ST_ISSUE;
      ST_ISSUE: begin
        bm_rd_en = (rem_q != '0) && credit_ok;
        if (bm_rd_en && issue_last) state_d = ST_DRAIN;
      end
      ST_DRAIN: if (pop && m_last) state_d = ST_DONE;
      default:  state_d = ST_IDLE;
    endcase
  end
  // address/remaining counters, in-flight count and read-latency valid/last delay line
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q   <= '0;
      rem_q    <= '0;
      inflight <= '0;
      sr_vld   <= '0;
      sr_lst   <= '0;
    end else begin
      if (req_valid && req_ready) begin
        addr_q <= req_addr;
        rem_q  <= req_len;
      end else if (bm_rd_en) begin
        addr_q <= (addr_q == AW'(DEPTH - 1)) ? '0 : addr_q + AW'(1);
        rem_q  <= rem_q - (AW+1)'(1);
      end
      inflight <= inflight + CW'(bm_rd_en) - CW'(sr_vld[RD_LAT-1]);
      sr_vld   <= RD_LAT'({sr_vld, bm_rd_en});
      sr_lst   <= RD_LAT'({sr_lst, bm_rd_en && issue_last});
    end
  end
  bm_rd_fifo #(.WIDTH(DATA_WIDTH + 1), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (sr_vld[RD_LAT-1]),
    .din   ({sr_lst[RD_LAT-1], bm_dout}),
    .pop   (pop),
    .dout  ({m_last, m_data}),
    .count (fifo_count),
    .empty (fifo_empty)
  );
endmodule
